// File: rtl/regfile_sb.sv
// Two-read / two-write CPU register file with a per-register busy scoreboard
// and a registered count of outstanding producers for the stall logic.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_busy,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic              HAS_ZERO  = (ZERO_REG != 0);
  localparam logic              HAS_BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wa_ok, wb_ok, iss_ok;
  logic              set_inc, wa_clr, wb_clr;

  // Forwarded read value; r0 is hard-wired and never bypassed.
  function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] stored);
    if (!ena || (HAS_ZERO && addr == ZERO_ADDR)) return {DATA_W{1'b0}};
    else if (HAS_BYP && wb_ok && wb_addr == addr) return wb_data;
    else if (HAS_BYP && wa_ok && wa_addr == addr) return wa_data;
    else return stored;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_W-1:0] addr, input logic stored);
    if (!ena) return 1'b0;
    else if (HAS_BYP && ((wa_ok && wa_addr == addr) || (wb_ok && wb_addr == addr))
             && !(iss_ok && iss_addr == addr)) return 1'b0;
    else return stored;
  endfunction

  // Qualified strobes and the incremental pending-count deltas.
  always_comb begin
    wa_ok   = ena & wa_en  & ~(HAS_ZERO & (wa_addr  == ZERO_ADDR));
    wb_ok   = ena & wb_en  & ~(HAS_ZERO & (wb_addr  == ZERO_ADDR));
    iss_ok  = ena & iss_en & ~(HAS_ZERO & (iss_addr == ZERO_ADDR));
    set_inc = iss_ok & ~busy_q[iss_addr];
    // Issue to the written register wins, so that write does not clear it.
    wa_clr  = wa_ok & busy_q[wa_addr] & ~(iss_ok & (iss_addr == wa_addr));
    wb_clr  = wb_ok & busy_q[wb_addr] & ~(iss_ok & (iss_addr == wb_addr))
            & ~(wa_clr & (wa_addr == wb_addr));
    cnt_d   = cnt_q + (ADDR_W+1)'(set_inc) - (ADDR_W+1)'(wa_clr) - (ADDR_W+1)'(wb_clr);
  end

  // Next array contents and busy bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_ok && wb_addr == ADDR_W'(i)) mem_d[i] = wb_data;
      else if (wa_ok && wa_addr == ADDR_W'(i)) mem_d[i] = wa_data;
      else mem_d[i] = mem_q[i];

      if (iss_ok && iss_addr == ADDR_W'(i)) busy_d[i] = 1'b1;
      else if ((wa_ok && wa_addr == ADDR_W'(i)) || (wb_ok && wb_addr == ADDR_W'(i)))
        busy_d[i] = 1'b0;
      else busy_d[i] = busy_q[i];
    end
  end

  // Read ports.
  always_comb begin
    ra_data  = rd_sel(ra_addr, mem_q[ra_addr]);
    rb_data  = rd_sel(rb_addr, mem_q[rb_addr]);
    ra_busy  = rd_busy(ra_addr, busy_q[ra_addr]);
    rb_busy  = rd_busy(rb_addr, busy_q[rb_addr]);
    pend_cnt = cnt_q;
  end

  // State registers; ena low leaves every _d equal to its _q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DATA_W{1'b0}};
      busy_q <= {DEPTH{1'b0}};
      cnt_q  <= {(ADDR_W+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst, ena;
  logic [4:0]  ra_addr, rb_addr, wa_addr, wb_addr, iss_addr;
  logic [31:0] ra_data, rb_data, wa_data, wb_data;
  logic        ra_busy, rb_busy, wa_en, wb_en, iss_en;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp_v;
  logic [31:0] btb_data[4];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
    .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; idle();
    wa_addr = 5'd0; wb_addr = 5'd0; iss_addr = 5'd0; wa_data = 32'h0; wb_data = 32'h0;
    ra_addr = 5'd0; rb_addr = 5'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      got = ra_data; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_ra_data[%0d]: got %h expected %h", i, got, exp_v); end
      got = rb_data; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_rb_data[%0d]: got %h expected %h", 31-i, got, exp_v); end
      got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_ra_busy[%0d]: got %h expected %h", i, got, exp_v); end
      got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_rb_busy[%0d]: got %h expected %h", 31-i, got, exp_v); end
    end
    exp_q.push_back(32'h0);
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_pend_cnt: got %0d expected %0d", got, exp_v); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'h0000AAAA;
    iss_en = 1'b1; iss_addr = 5'd2;
    tick();
    idle(); ra_addr = 5'd1; rb_addr = 5'd2;
    exp_q.push_back(32'h0000AAAA); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pre_rst_r1: got %h expected %h", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pre_rst_busy_r2: got %h expected %h", got, exp_v); end
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pre_rst_pend: got %0d expected %0d", got, exp_v); end
    // Mid-cycle, no clock edge in between.
    rst = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL async_rst_r1: got %h expected %h", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL async_rst_busy_r2: got %h expected %h", got, exp_v); end
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL async_rst_pend: got %0d expected %0d", got, exp_v); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF; ra_addr = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", got, exp_v); end
    tick();
    idle();
    exp_q.push_back(32'hDEADBEEF);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL bypass_next_cycle: got %h expected %h", got, exp_v); end
    // Dual write collision: port B wins in bypass and in the array.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
    ra_addr = 5'd7; rb_addr = 5'd0;
    exp_q.push_back(32'h22);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL collide_bypass: got %h expected %h", got, exp_v); end
    tick();
    idle();
    exp_q.push_back(32'h22);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL collide_stored: got %h expected %h", got, exp_v); end
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h0000FFFF;
    exp_q.push_back(32'h0);
    #1;
    got = rb_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL r0_no_bypass: got %h expected %h", got, exp_v); end
    tick();
    idle();
    exp_q.push_back(32'h0);
    #1;
    got = rb_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL r0_write_dropped: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      btb_data[k] = $urandom;
      wa_en = (k % 2 == 0); wb_en = (k % 2 == 1);
      wa_addr = 5'(20 + k); wb_addr = 5'(20 + k);
      wa_data = btb_data[k]; wb_data = btb_data[k];
      exp_q.push_back(btb_data[k]);
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      ra_addr = 5'(20 + k);
      #1;
      got = ra_data; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL b2b_r%0d: got %h expected %h", 20+k, got, exp_v); end
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    exp_q.push_back(32'd1);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_after_r3: got %0d expected %0d", got, exp_v); end
    iss_addr = 5'd4;
    tick();
    idle(); rb_addr = 5'd3; ra_addr = 5'd4;
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_after_r4: got %0d expected %0d", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_r3: got %h expected %h", got, exp_v); end
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_r4: got %h expected %h", got, exp_v); end
    // Clear both in one cycle; busy outputs drop already in that cycle.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h33;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_bypass_r3: got %h expected %h", got, exp_v); end
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_bypass_r4: got %h expected %h", got, exp_v); end
    tick();
    idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_dual_clear: got %0d expected %0d", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL cleared_r3: got %h expected %h", got, exp_v); end
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL cleared_r4: got %h expected %h", got, exp_v); end
    // Issue and write to busy r9 together: set wins.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h99; ra_addr = 5'd9;
    exp_q.push_back(32'h1);
    #1;
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL r9_busy_inflight: got %h expected %h", got, exp_v); end
    tick();
    idle();
    exp_q.push_back(32'h1); exp_q.push_back(32'd1);
    #1;
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL r9_set_wins: got %h expected %h", got, exp_v); end
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_set_wins: got %0d expected %0d", got, exp_v); end
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle(); ra_addr = 5'd0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h0);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_issue_r0: got %0d expected %0d", got, exp_v); end
    got = {31'b0, ra_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_r0: got %h expected %h", got, exp_v); end
    // Re-issue busy r9, then two writes to busy r10 (-1), then write non-busy r11.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_addr = 5'd10;
    tick();
    idle();
    exp_q.push_back(32'd2);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_reissue: got %0d expected %0d", got, exp_v); end
    wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'hA1;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hA2;
    tick();
    idle();
    exp_q.push_back(32'd1);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_same_reg_clear: got %0d expected %0d", got, exp_v); end
    wa_en = 1'b1; wa_addr = 5'd11; wa_data = 32'hB1;
    tick();
    idle();
    exp_q.push_back(32'd1);
    #1;
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL pend_nonbusy_write: got %0d expected %0d", got, exp_v); end
  endtask

  task automatic test_enable();
    // Live state: r5=DEADBEEF, r9 busy, pend_cnt=1.
    ena = 1'b0;
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h00001234;
    iss_en = 1'b1; iss_addr = 5'd12;
    ra_addr = 5'd5; rb_addr = 5'd9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'd1);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL dis_ra_data: got %h expected %h", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL dis_rb_busy: got %h expected %h", got, exp_v); end
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL dis_pend: got %0d expected %0d", got, exp_v); end
    tick();
    tick();
    idle(); ena = 1'b1;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h1); exp_q.push_back(32'd1);
    #1;
    got = ra_data; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reen_r5: got %h expected %h", got, exp_v); end
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reen_busy_r9: got %h expected %h", got, exp_v); end
    got = {26'b0, pend_cnt}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reen_pend: got %0d expected %0d", got, exp_v); end
    rb_addr = 5'd12;
    exp_q.push_back(32'h0);
    #1;
    got = {31'b0, rb_busy}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reen_busy_r12: got %h expected %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_bypass();
    test_back_to_back();
    test_scoreboard();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port CPU register file: 2 combinational read ports, 2 write ports (A = ALU writeback, B = load/multicycle writeback) and an optional write-to-read bypass.
- Adds a per-register busy scoreboard: set on instruction issue, cleared on writeback. The decode stage uses it to detect RAW hazards; stall logic uses a running pending-register count.
- Sits between decode/issue and writeback in the pipelined 54-instruction CPU.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  block enable; low freezes all state.
- ra_addr  in  ADDR_W  read port A index.
- ra_data  out  DATA_W  read port A data.
- ra_busy  out  1  register ra_addr has an outstanding producer.
- rb_addr  in  ADDR_W  read port B index.
- rb_data  out  DATA_W  read port B data.
- rb_busy  out  1  register rb_addr has an outstanding producer.
- wa_en  in  1  write port A strobe.
- wa_addr  in  ADDR_W  write port A index.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B strobe.
- wb_addr  in  ADDR_W  write port B index.
- wb_data  in  DATA_W  write port B data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- pend_cnt  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset:
  - rst high clears all registers, all busy bits and pend_cnt to 0 immediately.
  - Reset is independent of ena.
  - Reset mid-operation discards all pending writes and issues.
- Enable:
  - ena low blocks writes and issues; state holds.
  - ena low forces ra_data/rb_data to 0 and ra_busy/rb_busy to 0; pend_cnt still shows the held count.
- Writes:
  - Writes commit on the rising clk edge when ena is high.
  - Port A writes when wa_en is high; port B writes when wb_en is high.
  - Both ports to the same address in one cycle: port B data is stored.
  - With ZERO_REG=1, writes to index 0 are dropped.
- Reads:
  - Reads are combinational from the array; 0-cycle latency.
  - With BYPASS=1, if an enabled write targets the read address in the same cycle, the read returns the write data. Port B has priority over port A.
  - With ZERO_REG=1, index 0 reads 0 and no bypass applies to it.
  - With BYPASS=0, a read returns the old value until the edge.
- Scoreboard (per register, updated on clk when ena is high):
  - An enabled write on either port to register r clears busy[r].
  - iss_en sets busy[iss_addr].
  - Issue and write to the same register in one cycle: set wins (the new producer is outstanding).
  - Issue to a register already busy leaves it busy; the count is unchanged.
  - With ZERO_REG=1, issue to r0 is ignored.
  - A write to a non-busy register leaves the busy bit and count unchanged.
- ra_busy/rb_busy:
  - Combinational: busy[addr] of the current state.
  - With BYPASS=1, a clearing write in the same cycle (and no same-cycle issue to that register) drives the busy output to 0.
- pend_cnt:
  - Registered, equal to popcount(busy) at all times.
  - Updated incrementally: +1 for each newly set bit, −1 for each newly cleared bit.
  - Two writes to different busy registers in one cycle give −2. Two writes to the same busy register give −1.
  - Range 0..DEPTH; never wraps.

Test Plan:
- Reset, then read all 32 indices on both ports → all 0, all busy 0, pend_cnt=0. Assert rst asynchronously mid-cycle after writes → array zero before the next edge.
- wa writes r5=0xDEADBEEF while ra_addr=5 in the same cycle → ra_data=0xDEADBEEF in that cycle (BYPASS=1); the next cycle still reads 0xDEADBEEF.
- wa (r7=0x11) and wb (r7=0x22) in the same cycle → r7 reads 0x22; write r0=0xFFFF → r0 reads 0.
- Issue r3, r4 on consecutive cycles → pend_cnt 1, then 2; rb_addr=3 gives rb_busy=1. Then wa→r3 with wb→r4 in the same cycle → pend_cnt=0, both busy bits 0.
- Issue r9 with wa→r9 in the same cycle while r9 is busy → r9 stays busy, pend_cnt unchanged. Issue r0 → pend_cnt unchanged.
- ena=0 with wa_en/iss_en active → no state change, read outputs 0. Re-enable → previous contents and pend_cnt intact.
